// File: rtl/decode_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | decode_stage_if : fetch/writeback/execute bundle of the decode stage      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface decode_stage_if #(
  parameter int DATA_WIDTH = 16,
  parameter int PC_W       = 16,
  parameter int IR_W       = 32
) ();
  logic                  I_LOCK;
  logic [PC_W-1:0]       I_PC;
  logic [IR_W-1:0]       I_IR;
  logic                  I_FE_Valid;
  logic                  I_WB_Valid;
  logic [3:0]            I_WB_Dest;
  logic [DATA_WIDTH-1:0] I_WB_Data;
  logic                  I_BranchResolved;

  logic                  O_LOCK;
  logic [PC_W-1:0]       O_PC;
  logic [IR_W-1:0]       O_IR;
  logic                  O_DE_Valid;
  logic [DATA_WIDTH-1:0] O_Src1Value;
  logic [DATA_WIDTH-1:0] O_Src2Value;
  logic [3:0]            O_DestReg;
  logic [DATA_WIDTH-1:0] O_Imm;
  logic                  O_DepStallSignal;
  logic                  O_BranchStallSignal;

  modport master (
    output I_LOCK, I_PC, I_IR, I_FE_Valid, I_WB_Valid, I_WB_Dest, I_WB_Data, I_BranchResolved,
    input  O_LOCK, O_PC, O_IR, O_DE_Valid, O_Src1Value, O_Src2Value, O_DestReg, O_Imm,
           O_DepStallSignal, O_BranchStallSignal
  );

  modport slave (
    input  I_LOCK, I_PC, I_IR, I_FE_Valid, I_WB_Valid, I_WB_Dest, I_WB_Data, I_BranchResolved,
    output O_LOCK, O_PC, O_IR, O_DE_Valid, O_Src1Value, O_Src2Value, O_DestReg, O_Imm,
           O_DepStallSignal, O_BranchStallSignal
  );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | decode_stage : regfile, busy scoreboard, dep/branch stalls (negedge)      |
// | Option macro: DECODE_WB_BYPASS_EN (writeback forwarding)  Rev 1.0        |
// +--------------------------------------------------------------------------+
module decode_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 16,
  parameter int PC_W       = 16,
  parameter int IR_W       = 32
) (
  input  logic          I_CLOCK,
  input  logic          I_RESET_N,
  decode_stage_if.slave bus
);
  localparam logic [IR_W-1:0] c_NOP_IR = IR_W'(32'hFF000000);

  logic [DATA_WIDTH-1:0] rf_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] rf_d [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic                  bp_q, bp_d;
  logic                  lock_q, lock_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  logic [IR_W-1:0]       ir_q, ir_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] src1_q, src1_d, src2_q, src2_d, imm_q, imm_d;
  logic [3:0]            dest_q, dest_d;

  logic [3:0]            w_op, w_s1, w_s2, w_dst;
  logic                  w_rd1, w_rd2, w_wr, w_br;
  logic [NUM_REGS-1:0]   w_busy_eff;
  logic [DATA_WIDTH-1:0] w_src1_val, w_src2_val;
  logic                  w_front_ok, w_hazard, w_issue;

  assign w_op  = bus.I_IR[31:28];
  assign w_dst = bus.I_IR[23:20];
  assign w_s1  = bus.I_IR[19:16];
  assign w_s2  = bus.I_IR[11:8];

  always_comb begin
    w_rd1 = 1'b0;
    w_rd2 = 1'b0;
    w_wr  = 1'b0;
    w_br  = 1'b0;
    case (w_op)
      4'h0:    begin w_rd1 = 1'b1; w_rd2 = 1'b1; w_wr = 1'b1; end
      4'h1:    begin w_rd1 = 1'b1; w_wr = 1'b1; end
      4'h2:    begin w_rd1 = 1'b1; w_wr = 1'b1; end
      4'h3:    begin w_rd1 = 1'b1; w_rd2 = 1'b1; end
      4'h4:    begin w_rd1 = 1'b1; w_rd2 = 1'b1; w_br = 1'b1; end
      4'h5:    w_br = 1'b1;
      default: ;
    endcase
  end

`ifdef DECODE_WB_BYPASS_EN
  // A register being written back this edge is treated as already free.
  assign w_busy_eff = busy_q & ~(bus.I_WB_Valid ? (NUM_REGS'(1) << bus.I_WB_Dest) : '0);
  assign w_src1_val = (bus.I_WB_Valid && (bus.I_WB_Dest == w_s1)) ? bus.I_WB_Data : rf_q[w_s1];
  assign w_src2_val = (bus.I_WB_Valid && (bus.I_WB_Dest == w_s2)) ? bus.I_WB_Data : rf_q[w_s2];
`else
  assign w_busy_eff = busy_q;
  assign w_src1_val = rf_q[w_s1];
  assign w_src2_val = rf_q[w_s2];
`endif

  assign w_front_ok = bus.I_FE_Valid & ~bus.I_LOCK & ~bp_q;
  assign w_hazard   = w_front_ok & ((w_rd1 & w_busy_eff[w_s1]) |
                                    (w_rd2 & w_busy_eff[w_s2]) |
                                    (w_wr  & w_busy_eff[w_dst]));
  assign w_issue    = w_front_ok & ~w_hazard;

  always_comb begin
    rf_d   = rf_q;
    busy_d = busy_q;
    if (bus.I_WB_Valid) begin
      rf_d[bus.I_WB_Dest]   = bus.I_WB_Data;
      busy_d[bus.I_WB_Dest] = 1'b0;
    end
    // Issue's set is applied after the writeback clear so it wins on a tie.
    if (w_issue && w_wr) busy_d[w_dst] = 1'b1;

    bp_d = bp_q;
    if (bp_q && bus.I_BranchResolved) bp_d = 1'b0;
    else if (w_issue && w_br)         bp_d = 1'b1;

    lock_d  = bus.I_LOCK;
    valid_d = w_issue;
    ir_d    = w_issue ? bus.I_IR : c_NOP_IR;
    pc_d    = pc_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    dest_d  = dest_q;
    imm_d   = imm_q;
    if (w_issue) begin
      pc_d   = bus.I_PC;
      src1_d = w_src1_val;
      src2_d = w_src2_val;
      dest_d = w_dst;
      imm_d  = DATA_WIDTH'(bus.I_IR[15:0]);
    end
  end

  always_ff @(negedge I_CLOCK) begin
    if (!I_RESET_N) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
      busy_q  <= '0;
      bp_q    <= 1'b0;
      lock_q  <= 1'b0;
      pc_q    <= '0;
      ir_q    <= c_NOP_IR;
      valid_q <= 1'b0;
      src1_q  <= '0;
      src2_q  <= '0;
      dest_q  <= '0;
      imm_q   <= '0;
    end else begin
      rf_q    <= rf_d;
      busy_q  <= busy_d;
      bp_q    <= bp_d;
      lock_q  <= lock_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      dest_q  <= dest_d;
      imm_q   <= imm_d;
    end
  end

  assign bus.O_LOCK              = lock_q;
  assign bus.O_PC                = pc_q;
  assign bus.O_IR                = ir_q;
  assign bus.O_DE_Valid          = valid_q;
  assign bus.O_Src1Value         = src1_q;
  assign bus.O_Src2Value         = src2_q;
  assign bus.O_DestReg           = dest_q;
  assign bus.O_Imm               = imm_q;
  assign bus.O_DepStallSignal    = w_hazard;
  assign bus.O_BranchStallSignal = bp_q;
endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_decode_stage : directed self-checking bench for decode_stage          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_decode_stage;
  localparam logic [31:0] c_NOP = 32'hFF000000;

  logic I_CLOCK;
  logic I_RESET_N;
  int   errors = 0;
  int   checks = 0;

  decode_stage_if #(.DATA_WIDTH(16), .PC_W(16), .IR_W(32)) bus ();

  decode_stage #(.DATA_WIDTH(16), .NUM_REGS(16), .PC_W(16), .IR_W(32)) dut (
    .I_CLOCK  (I_CLOCK),
    .I_RESET_N(I_RESET_N),
    .bus      (bus)
  );

  initial begin
    I_CLOCK = 1'b1;
    forever #5 I_CLOCK = ~I_CLOCK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge I_CLOCK);
    #1;
  endtask

  task automatic fe(input logic v, input logic [15:0] pc, input logic [31:0] ir);
    bus.I_FE_Valid = v;
    bus.I_PC       = pc;
    bus.I_IR       = ir;
  endtask

  task automatic wb(input logic v, input logic [3:0] d, input logic [15:0] data);
    bus.I_WB_Valid = v;
    bus.I_WB_Dest  = d;
    bus.I_WB_Data  = data;
  endtask

  initial begin
    I_RESET_N            = 1'b0;
    bus.I_LOCK           = 1'b0;
    bus.I_BranchResolved = 1'b0;
    fe(1'b0, 16'h0, c_NOP);
    wb(1'b0, 4'h0, 16'h0);
    tick();
    tick();
    chk("rst_ir",    bus.O_IR, c_NOP);
    chk("rst_valid", 32'(bus.O_DE_Valid), 0);
    chk("rst_pc",    32'(bus.O_PC), 0);
    chk("rst_lock",  32'(bus.O_LOCK), 0);
    chk("rst_bstall", 32'(bus.O_BranchStallSignal), 0);
    chk("rst_src1",  32'(bus.O_Src1Value), 0);
    chk("rst_dest",  32'(bus.O_DestReg), 0);

    I_RESET_N = 1'b1;
    fe(1'b0, 16'h0010, c_NOP);
    tick();
    chk("nop_ir",     bus.O_IR, c_NOP);
    chk("nop_valid",  32'(bus.O_DE_Valid), 0);
    chk("nop_pc",     32'(bus.O_PC), 0);
    chk("nop_dstall", 32'(bus.O_DepStallSignal), 0);
    chk("nop_bstall", 32'(bus.O_BranchStallSignal), 0);

    // r3 <= 1234, then ALU-reg r5 = r3 op r3
    wb(1'b1, 4'd3, 16'h1234);
    tick();
    wb(1'b0, 4'd0, 16'h0);
    fe(1'b1, 16'h0020, 32'h0053_0300);
    #1 chk("alu_dstall", 32'(bus.O_DepStallSignal), 0);
    tick();
    chk("alu_valid", 32'(bus.O_DE_Valid), 1);
    chk("alu_ir",    bus.O_IR, 32'h0053_0300);
    chk("alu_pc",    32'(bus.O_PC), 32'h0020);
    chk("alu_src1",  32'(bus.O_Src1Value), 32'h1234);
    chk("alu_src2",  32'(bus.O_Src2Value), 32'h1234);
    chk("alu_dest",  32'(bus.O_DestReg), 5);
    chk("alu_imm",   32'(bus.O_Imm), 32'h0300);

    // ALU-imm r6 = r5 + 7 : r5 busy
    fe(1'b1, 16'h0024, 32'h1065_0007);
    #1 chk("raw_dstall", 32'(bus.O_DepStallSignal), 1);
    tick();
    chk("raw_valid", 32'(bus.O_DE_Valid), 0);
    chk("raw_ir",    bus.O_IR, c_NOP);
    wb(1'b1, 4'd5, 16'h00AA);
`ifdef DECODE_WB_BYPASS_EN
    #1 chk("wb_dstall", 32'(bus.O_DepStallSignal), 0);
    tick();
    wb(1'b0, 4'd0, 16'h0);
`else
    #1 chk("wb_dstall", 32'(bus.O_DepStallSignal), 1);
    tick();
    chk("wb_valid0", 32'(bus.O_DE_Valid), 0);
    wb(1'b0, 4'd0, 16'h0);
    #1 chk("wb_dstall1", 32'(bus.O_DepStallSignal), 0);
    tick();
`endif
    chk("raw_issue", 32'(bus.O_DE_Valid), 1);
    chk("raw_src1",  32'(bus.O_Src1Value), 32'h00AA);
    chk("raw_dest",  32'(bus.O_DestReg), 6);
    chk("raw_imm",   32'(bus.O_Imm), 7);

    // BRANCH r3,r3 then three wrong-path instructions
    fe(1'b1, 16'h0030, 32'h4003_0300);
    tick();
    chk("br_valid",  32'(bus.O_DE_Valid), 1);
    chk("br_bstall", 32'(bus.O_BranchStallSignal), 1);
    fe(1'b1, 16'h0034, 32'h1083_0001);
    for (int i = 0; i < 3; i++) begin
      #1 chk("wp_dstall", 32'(bus.O_DepStallSignal), 0);
      tick();
      chk("wp_valid",  32'(bus.O_DE_Valid), 0);
      chk("wp_ir",     bus.O_IR, c_NOP);
      chk("wp_bstall", 32'(bus.O_BranchStallSignal), 1);
    end
    bus.I_BranchResolved = 1'b1;
    tick();
    bus.I_BranchResolved = 1'b0;
    chk("res_valid",  32'(bus.O_DE_Valid), 0);
    chk("res_bstall", 32'(bus.O_BranchStallSignal), 0);
    tick();
    chk("post_valid", 32'(bus.O_DE_Valid), 1);
    chk("post_ir",    bus.O_IR, 32'h1083_0001);
    chk("post_dest",  32'(bus.O_DestReg), 8);

    // Resolve pulse with no branch pending has no effect
    fe(1'b0, 16'h0038, c_NOP);
    bus.I_BranchResolved = 1'b1;
    tick();
    bus.I_BranchResolved = 1'b0;
    chk("idle_res_bstall", 32'(bus.O_BranchStallSignal), 0);

    // Lock: write to r9 presented but must not issue or mark busy
    bus.I_LOCK = 1'b1;
    fe(1'b1, 16'h0040, 32'h1093_0000);
    #1 chk("lock_dstall", 32'(bus.O_DepStallSignal), 0);
    tick();
    chk("lock_o",     32'(bus.O_LOCK), 1);
    chk("lock_valid", 32'(bus.O_DE_Valid), 0);
    bus.I_LOCK = 1'b0;
    fe(1'b1, 16'h0044, 32'h10A9_0000);
    #1 chk("lock_r9free", 32'(bus.O_DepStallSignal), 0);
    tick();
    chk("unlock_o",     32'(bus.O_LOCK), 0);
    chk("unlock_valid", 32'(bus.O_DE_Valid), 1);

    // Issue write to r7 on the same edge as writeback of r7
    fe(1'b1, 16'h0048, 32'h1073_0000);
    wb(1'b1, 4'd7, 16'hBEEF);
    tick();
    wb(1'b0, 4'd0, 16'h0);
    chk("same_valid", 32'(bus.O_DE_Valid), 1);
    chk("same_rf7",   32'(dut.rf_q[7]), 32'hBEEF);
    chk("same_busy7", 32'(dut.busy_q[7]), 1);
    fe(1'b1, 16'h004C, 32'h1017_0000);
    #1 chk("same_dstall", 32'(bus.O_DepStallSignal), 1);

    // Reset while stalled drops the instruction and clears the scoreboard
    I_RESET_N = 1'b0;
    tick();
    chk("mrst_valid",  32'(bus.O_DE_Valid), 0);
    chk("mrst_ir",     bus.O_IR, c_NOP);
    I_RESET_N = 1'b1;
    #1 chk("mrst_dstall", 32'(bus.O_DepStallSignal), 0);
    tick();
    chk("mrst_issue", 32'(bus.O_DE_Valid), 1);
    chk("mrst_src1",  32'(bus.O_Src1Value), 0);
    chk("mrst_pc",    32'(bus.O_PC), 32'h004C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
